// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and helpers for the instruction loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES = 2;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles little-endian words from a byte stream
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  word_done,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    generate
        if (BPW == 1) begin : g_single
            assign word_done = in_valid;
            assign word      = in_byte;
        end else begin : g_multi
            logic [CW-1:0]           cnt;
            logic [DATA_WIDTH-9:0]   lower;

            // The final byte bypasses storage so the word is available on the accepting cycle.
            assign word_done = in_valid && (cnt == CW'(BPW - 1));
            assign word      = {in_byte, lower};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt   <= '0;
                    lower <= '0;
                end else if (clr) begin
                    cnt   <= '0;
                    lower <= '0;
                end else if (in_valid) begin
                    for (int i = 0; i < BPW - 1; i++) begin
                        if (cnt == CW'(i)) begin
                            lower[i*8 +: 8] <= in_byte;
                        end
                    end
                    cnt <= word_done ? '0 : cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader writing a checksummed byte-serial image into instruction memory
module instr_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int          WLW      = ADDR_WIDTH + 1;
    localparam logic [16:0] CAPACITY = 17'(1 << ADDR_WIDTH);

    loader_state_t         state, state_next;
    logic [7:0]            len_lo;
    logic [15:0]           n_words;
    logic [7:0]            checksum;
    logic                  start_go;
    logic                  accept;
    logic                  pk_valid;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;
    logic [15:0]           len_in;
    logic                  last_word;

    assign accept    = rx_valid & rx_ready;
    assign pk_valid  = accept && (state == DATA);
    assign len_in    = {rx_data, len_lo};
    assign last_word = (16'(words_loaded) + 16'd1) == n_words;

    byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_go),
        .in_valid  (pk_valid),
        .in_byte   (rx_data),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        start_go   = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    start_go   = 1'b1;
                    state_next = LEN0;
                end
            end
            LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = LEN1;
            end
            LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, len_in} > CAPACITY) state_next = ERROR;
                    else if (len_in == 16'd0)      state_next = CHECK;
                    else                           state_next = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && word_done && last_word) state_next = CHECK;
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = (rx_data == checksum) ? DONE : ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered copies of the upcoming state, so they land one cycle after the deciding byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            len_lo       <= '0;
            n_words      <= '0;
        end else begin
            mem_we   <= 1'b0;
            done     <= (state_next == DONE);
            error    <= (state_next == ERROR);
            cpu_hold <= (state_next != DONE);
            if (start_go) begin
                checksum     <= '0;
                words_loaded <= '0;
            end
            if (state == LEN0 && accept) len_lo  <= rx_data;
            if (state == LEN1 && accept) n_words <= len_in;
            if (pk_valid) begin
                checksum <= checksum ^ rx_data;
                if (word_done) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                    mem_wdata    <= word;
                    words_loaded <= words_loaded + WLW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int total = 0;
    int passed = 0;
    int n_writes = 0;

    instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) n_writes++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic nominal(input string tag, input logic [7:0] csum);
        do_start();
        check({tag, "_len0_ready"}, rx_ready, 1);
        check({tag, "_len0_hold"}, cpu_hold, 1);
        check({tag, "_len0_done"}, done, 0);
        check({tag, "_len0_error"}, error, 0);
        send(8'h02); send(8'h00);
        send(8'h05); send(8'h00); send(8'hA0); send(8'hE3);
        check({tag, "_w0_we"}, mem_we, 1);
        check({tag, "_w0_addr"}, mem_addr, 0);
        check({tag, "_w0_data"}, mem_wdata, 32'hE3A00005);
        check({tag, "_w0_count"}, words_loaded, 1);
        send(8'h01);
        check({tag, "_w0_pulse_end"}, mem_we, 0);
        send(8'h10); send(8'h80); send(8'hE2);
        check({tag, "_w1_we"}, mem_we, 1);
        check({tag, "_w1_addr"}, mem_addr, 1);
        check({tag, "_w1_data"}, mem_wdata, 32'hE2801001);
        check({tag, "_w1_count"}, words_loaded, 2);
        check({tag, "_check_ready"}, rx_ready, 1);
        send(csum);
    endtask

    initial begin
        #3 reset = 1'b1;
        #1 check_reset_values("reset_async");
        #4 reset = 1'b0;
        step();
        check("idle_ready", rx_ready, 0);

        nominal("nom", 8'h35);
        check("nom_done", done, 1);
        check("nom_hold", cpu_hold, 0);
        check("nom_error", error, 0);
        check("nom_count", words_loaded, 2);
        check("nom_ready", rx_ready, 0);
        check("nom_we_low", mem_we, 0);
        check("nom_addr_hold", mem_addr, 1);
        check("nom_data_hold", mem_wdata, 32'hE2801001);
        check("nom_writes", n_writes, 2);
        step();
        check("nom_done_stays", done, 1);

        nominal("bad", 8'h34);
        check("bad_error", error, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        check("bad_ready", rx_ready, 0);
        check("bad_writes", n_writes, 4);
        nominal("retry", 8'h35);
        check("retry_done", done, 1);
        check("retry_error", error, 0);
        check("retry_hold", cpu_hold, 0);
        check("retry_writes", n_writes, 6);

        do_start();
        send(8'h41);
        check("ovl_len1_error", error, 0);
        send(8'h00);
        check("ovl_error", error, 1);
        check("ovl_done", done, 0);
        check("ovl_hold", cpu_hold, 1);
        check("ovl_ready", rx_ready, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        step(); step();
        rx_valid = 1'b0;
        check("ovl_no_we", mem_we, 0);
        check("ovl_writes", n_writes, 6);

        do_start();
        send(8'h00);
        rx_data = 8'h55;
        step();
        check("zero_gap1_ready", rx_ready, 1);
        send(8'h00);
        rx_data = 8'hAA;
        step();
        check("zero_gap2_ready", rx_ready, 1);
        check("zero_gap2_done", done, 0);
        send(8'h00);
        check("zero_done", done, 1);
        check("zero_error", error, 0);
        check("zero_hold", cpu_hold, 0);
        check("zero_count", words_loaded, 0);
        check("zero_writes", n_writes, 6);

        do_start();
        send(8'h02); send(8'h00);
        send(8'h05); send(8'h00); send(8'hA0); send(8'hE3);
        send(8'h01);
        check("mid_writes_before", n_writes, 7);
        #2 reset = 1'b1;
        #1 check_reset_values("reset_mid");
        #3 reset = 1'b0;
        step(); step(); step();
        check("mid_idle_ready", rx_ready, 0);
        check("mid_writes_after", n_writes, 7);
        nominal("reload", 8'h35);
        check("reload_done", done, 1);
        check("reload_hold", cpu_hold, 0);
        check("reload_count", words_loaded, 2);
        check("reload_writes", n_writes, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
